// File: rtl/tcam_fanout_pkg.sv
// rtl/tcam_fanout_pkg.sv - shared types for the TCAM fan-out engine
package tcam_fanout_pkg;

    // Default geometry of one entry; the engine itself is parametrised
    localparam int DEF_ID_WIDTH     = 4;
    localparam int DEF_AXON_WIDTH   = 2;
    localparam int DEF_SYN_WIDTH    = 2;
    localparam int DEF_WEIGHT_WIDTH = 4;
    localparam int DEF_BITS         = DEF_ID_WIDTH + DEF_AXON_WIDTH + DEF_SYN_WIDTH;

    // Command codes carried on Mode_In
    typedef enum logic [2:0] {
        MODE_I   = 3'b000,
        MODE_W   = 3'b001,
        MODE_R   = 3'b010,
        MODE_F   = 3'b011,
        MODE_C   = 3'b100,
        MODE_CLR = 3'b101
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_EMIT   = 2'd2
    } state_e;

    // One TCAM entry at the default geometry
    typedef struct packed {
        logic [DEF_BITS-1:0]         key;
        logic [DEF_BITS-1:0]         mask;
        logic                        vb;
        logic [DEF_ID_WIDTH-1:0]     dst;
        logic [DEF_WEIGHT_WIDTH-1:0] weight;
    } entry_t;

endpackage

// File: rtl/tcam_fanout_prio_enc.sv
// rtl/tcam_fanout_prio_enc.sv - lowest-set-bit encoder with single-bit-remaining flag
module tcam_prio_enc
    import tcam_fanout_pkg::*;
#(
    parameter int WORDS      = 16,
    parameter int ADDR_WIDTH = $clog2(WORDS)
) (
    input  logic [WORDS-1:0]      vec,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic                  last
);

    // Scan from the top so the lowest set bit wins
    always_comb begin
        idx = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ADDR_WIDTH'(i);
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing
    assign last = (vec != '0) && ((vec & (vec - WORDS'(1))) == '0);

endmodule

// File: rtl/tcam_fanout_engine.sv
// rtl/tcam_fanout_engine.sv - ternary match memory with lowest-first fan-out stream
module tcam_fanout_engine
    import tcam_fanout_pkg::*;
#(
    parameter int ID_WIDTH     = 4,
    parameter int AXON_WIDTH   = 2,
    parameter int SYN_WIDTH    = 2,
    parameter int WEIGHT_WIDTH = 4,
    parameter int WORDS        = 16,
    parameter int ADDR_WIDTH   = $clog2(WORDS),
    parameter int BITS         = ID_WIDTH + AXON_WIDTH + SYN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              Mode_In,
    input  logic                    Cmd_Valid,
    output logic                    Cmd_Ready,
    input  logic [BITS-1:0]         Data_In,
    input  logic [BITS-1:0]         Mskb_In,
    input  logic [ADDR_WIDTH-1:0]   A_In,
    input  logic                    Vbi_In,
    input  logic [ID_WIDTH-1:0]     Dst_In,
    input  logic [WEIGHT_WIDTH-1:0] Weight_In,
    output logic                    Rd_Valid,
    output logic [BITS-1:0]         Rd_Key,
    output logic [BITS-1:0]         Rd_Mskb,
    output logic                    Rd_Vb,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [ID_WIDTH-1:0]     DstID_Out,
    output logic [WEIGHT_WIDTH-1:0] Weight_Out,
    output logic                    Out_Last,
    output logic [ADDR_WIDTH:0]     Hit_Count,
    output logic                    Miss
);

    logic [BITS-1:0]         key_mem  [WORDS];
    logic [BITS-1:0]         mask_mem [WORDS];
    logic [ID_WIDTH-1:0]     dst_mem  [WORDS];
    logic [WEIGHT_WIDTH-1:0] wt_mem   [WORDS];
    logic [WORDS-1:0]        vb;

    state_e                  state;
    mode_e                   mode;
    logic                    accept;
    logic [WORDS-1:0]        match_vec;
    logic [ADDR_WIDTH:0]     match_cnt;
    logic [WORDS-1:0]        hit_vec;
    logic [ADDR_WIDTH-1:0]   emit_idx;
    logic                    emit_last;

    assign mode      = mode_e'(Mode_In);
    assign Cmd_Ready = (state == ST_IDLE);
    assign accept    = Cmd_Valid && Cmd_Ready;

    // Parallel ternary compare of every entry against the incoming key, plus hit count
    always_comb begin
        match_vec = '0;
        match_cnt = '0;
        for (int i = 0; i < WORDS; i++) begin
            match_vec[i] = vb[i] && (((key_mem[i] ^ Data_In) & mask_mem[i]) == '0);
            match_cnt    = match_cnt + (ADDR_WIDTH + 1)'(match_vec[i]);
        end
    end

    tcam_prio_enc #(
        .WORDS      (WORDS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prio_enc (
        .vec  (hit_vec),
        .idx  (emit_idx),
        .last (emit_last)
    );

    // Payload comes straight from the array; it is frozen while the engine is busy
    assign Out_Valid  = (state == ST_EMIT);
    assign DstID_Out  = Out_Valid ? dst_mem[emit_idx] : '0;
    assign Weight_Out = Out_Valid ? wt_mem[emit_idx]  : '0;
    assign Out_Last   = Out_Valid && emit_last;

    // Key, mask and payload storage; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (!rst && accept && (mode == MODE_W)) begin
            key_mem[A_In]  <= Data_In;
            mask_mem[A_In] <= Mskb_In;
            dst_mem[A_In]  <= Dst_In;
            wt_mem[A_In]   <= Weight_In;
        end
    end

    // Command decode, valid bits, read port and the fire state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            vb        <= '0;
            hit_vec   <= '0;
            Hit_Count <= '0;
            Miss      <= 1'b0;
            Rd_Valid  <= 1'b0;
            Rd_Key    <= '0;
            Rd_Mskb   <= '0;
            Rd_Vb     <= 1'b0;
        end else begin
            Rd_Valid <= 1'b0;
            Miss     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (mode)
                            MODE_W: vb[A_In] <= Vbi_In;
                            MODE_R: begin
                                Rd_Valid <= 1'b1;
                                Rd_Key   <= key_mem[A_In];
                                Rd_Mskb  <= mask_mem[A_In];
                                Rd_Vb    <= vb[A_In];
                            end
                            MODE_F: begin
                                hit_vec   <= match_vec;
                                Hit_Count <= match_cnt;
                                state     <= ST_SEARCH;
                            end
                            MODE_C: begin
                                hit_vec   <= match_vec;
                                Hit_Count <= match_cnt;
                            end
                            MODE_CLR: vb <= '0;
                            default: ;
                        endcase
                    end
                end
                ST_SEARCH: begin
                    if (hit_vec == '0) begin
                        Miss  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (Out_Ready) begin
                        hit_vec[emit_idx] <= 1'b0;
                        if (emit_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcam_fanout_engine.sv
// tb/tb_tcam_fanout_engine.sv - self-checking bench for the TCAM fan-out engine
`timescale 1ns/1ps
module tb_tcam_fanout_engine;
    import tcam_fanout_pkg::*;

    localparam int WORDS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] Mode_In;
    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic [7:0] Data_In;
    logic [7:0] Mskb_In;
    logic [3:0] A_In;
    logic       Vbi_In;
    logic [3:0] Dst_In;
    logic [3:0] Weight_In;
    logic       Rd_Valid;
    logic [7:0] Rd_Key;
    logic [7:0] Rd_Mskb;
    logic       Rd_Vb;
    logic       Out_Valid;
    logic       Out_Ready;
    logic [3:0] DstID_Out;
    logic [3:0] Weight_Out;
    logic       Out_Last;
    logic [4:0] Hit_Count;
    logic       Miss;

    tcam_fanout_engine dut (
        .clk(clk), .rst(rst), .Mode_In(Mode_In), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
        .Data_In(Data_In), .Mskb_In(Mskb_In), .A_In(A_In), .Vbi_In(Vbi_In), .Dst_In(Dst_In),
        .Weight_In(Weight_In), .Rd_Valid(Rd_Valid), .Rd_Key(Rd_Key), .Rd_Mskb(Rd_Mskb),
        .Rd_Vb(Rd_Vb), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .DstID_Out(DstID_Out),
        .Weight_Out(Weight_Out), .Out_Last(Out_Last), .Hit_Count(Hit_Count), .Miss(Miss)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    entry_t model   [WORDS];
    bit     written [WORDS];

    typedef struct {
        mode_e      m;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] mk;
        logic       vbi;
        logic [3:0] dst;
        logic [3:0] wt;
        bit         chk_rd;
        bit         chk_key;
        bit         chk_cnt;
        logic [7:0] e_key;
        logic [7:0] e_mk;
        logic       e_vb;
        logic [4:0] e_cnt;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_hit(input int i, input logic [7:0] k);
        return model[i].vb && (((model[i].key ^ k) & model[i].mask) == 8'h00);
    endfunction

    function automatic int model_count(input logic [7:0] k);
        int n = 0;
        for (int i = 0; i < WORDS; i++) if (model_hit(i, k)) n++;
        return n;
    endfunction

    task automatic issue(input mode_e m, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] mk, input logic vbi, input logic [3:0] dst,
                         input logic [3:0] wt);
        check("cmd_ready_before", Cmd_Ready, 1);
        Mode_In = m; A_In = a; Data_In = d; Mskb_In = mk;
        Vbi_In = vbi; Dst_In = dst; Weight_In = wt; Cmd_Valid = 1'b1;
        step();
        Cmd_Valid = 1'b0;
        if (m == MODE_W) begin
            model[a] = '{key: d, mask: mk, vb: vbi, dst: dst, weight: wt};
            written[a] = 1'b1;
        end else if (m == MODE_CLR) begin
            for (int i = 0; i < WORDS; i++) model[i].vb = 1'b0;
        end
    endtask

    task automatic rd_check(input logic [3:0] a);
        issue(MODE_R, a, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0);
        check("rd_valid", Rd_Valid, 1);
        check("rd_vb", Rd_Vb, model[a].vb);
        if (written[a]) begin
            check("rd_key", Rd_Key, model[a].key);
            check("rd_mskb", Rd_Mskb, model[a].mask);
        end
        step();
        check("rd_valid_pulse", Rd_Valid, 0);
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = stall first beat 3 cycles
    task automatic fire(input logic [7:0] k, input int ready_mode, input bit poke);
        int exp_q[$];
        int n, beat, cyc, stall;
        exp_q = {};
        for (int i = 0; i < WORDS; i++) if (model_hit(i, k)) exp_q.push_back(i);
        n = exp_q.size();
        issue(MODE_F, 4'h0, k, 8'h00, 1'b0, 4'h0, 4'h0);
        check("search_busy", Cmd_Ready, 0);
        check("search_ov", Out_Valid, 0);
        check("hit_count", Hit_Count, n);
        step();
        if (n == 0) begin
            check("miss_pulse", Miss, 1);
            check("miss_ov", Out_Valid, 0);
            check("miss_ready", Cmd_Ready, 1);
            step();
            check("miss_drop", Miss, 0);
            check("miss_ov2", Out_Valid, 0);
            return;
        end
        check("no_miss", Miss, 0);
        beat = 0; cyc = 0; stall = 0;
        while (beat < n && cyc < 200) begin
            check("beat_valid", Out_Valid, 1);
            check("beat_dst", DstID_Out, model[exp_q[beat]].dst);
            check("beat_wt", Weight_Out, model[exp_q[beat]].weight);
            check("beat_last", Out_Last, (beat == n - 1));
            check("beat_busy", Cmd_Ready, 0);
            case (ready_mode)
                0: Out_Ready = 1'b1;
                1: Out_Ready = 1'($urandom_range(0, 1));
                default: begin
                    Out_Ready = !(beat == 0 && stall < 3);
                    if (!Out_Ready) stall++;
                end
            endcase
            if (poke) begin
                Mode_In = MODE_W; A_In = 4'($urandom_range(0, 15)); Data_In = 8'($urandom);
                Mskb_In = 8'($urandom); Vbi_In = 1'b1; Cmd_Valid = 1'b1;
            end
            step();
            Cmd_Valid = 1'b0;
            if (Out_Ready) beat++;
            cyc++;
        end
        if (beat < n) check("fire_timeout", beat, n);
        check("end_ov", Out_Valid, 0);
        check("end_ready", Cmd_Ready, 1);
    endtask

    initial begin
        rst = 1'b1; Mode_In = 3'b000; Cmd_Valid = 1'b0; Data_In = '0; Mskb_In = '0;
        A_In = '0; Vbi_In = 1'b0; Dst_In = '0; Weight_In = '0; Out_Ready = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            model[i] = '0;
            written[i] = 1'b0;
        end

        //           mode      a      d      mk     vbi   dst   wt    rd  key cnt  ekey   emk    evb   ecnt
        tbl[0]  = '{MODE_R,   4'd5, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 1, 0, 0, 8'h00, 8'h00, 1'b0, 5'd0};
        tbl[1]  = '{MODE_W,   4'd1, 8'h00, 8'hFF, 1'b1, 4'h3, 4'h7, 0, 0, 0, 8'h00, 8'h00, 1'b0, 5'd0};
        tbl[2]  = '{MODE_R,   4'd1, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 1, 1, 0, 8'h00, 8'hFF, 1'b1, 5'd0};
        tbl[3]  = '{MODE_W,   4'd2, 8'h50, 8'hF0, 1'b1, 4'h9, 4'h2, 0, 0, 0, 8'h00, 8'h00, 1'b0, 5'd0};
        tbl[4]  = '{MODE_W,   4'd7, 8'h53, 8'hFF, 1'b1, 4'h4, 4'h1, 0, 0, 0, 8'h00, 8'h00, 1'b0, 5'd0};
        tbl[5]  = '{MODE_C,   4'd0, 8'h53, 8'h00, 1'b0, 4'h0, 4'h0, 0, 0, 1, 8'h00, 8'h00, 1'b0, 5'd2};
        tbl[6]  = '{MODE_C,   4'd0, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 0, 0, 1, 8'h00, 8'h00, 1'b0, 5'd1};
        tbl[7]  = '{MODE_R,   4'd2, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 1, 1, 0, 8'h50, 8'hF0, 1'b1, 5'd0};
        tbl[8]  = '{MODE_W,   4'd9, 8'h53, 8'h00, 1'b0, 4'h5, 4'h5, 0, 0, 0, 8'h00, 8'h00, 1'b0, 5'd0};
        tbl[9]  = '{MODE_C,   4'd0, 8'hAA, 8'h00, 1'b0, 4'h0, 4'h0, 0, 0, 1, 8'h00, 8'h00, 1'b0, 5'd0};
        tbl[10] = '{MODE_W,   4'd9, 8'h53, 8'h00, 1'b1, 4'h5, 4'h5, 0, 0, 0, 8'h00, 8'h00, 1'b0, 5'd0};
        tbl[11] = '{MODE_C,   4'd0, 8'hAA, 8'h00, 1'b0, 4'h0, 4'h0, 0, 0, 1, 8'h00, 8'h00, 1'b0, 5'd1};
        tbl[12] = '{MODE_W,   4'd9, 8'h53, 8'h00, 1'b0, 4'h5, 4'h5, 0, 0, 0, 8'h00, 8'h00, 1'b0, 5'd0};

        repeat (3) step();
        check("rst_cmd_ready", Cmd_Ready, 1);
        check("rst_out_valid", Out_Valid, 0);
        check("rst_rd_valid", Rd_Valid, 0);
        check("rst_hit_count", Hit_Count, 0);
        check("rst_miss", Miss, 0);
        check("rst_dst", DstID_Out, 0);
        check("rst_last", Out_Last, 0);
        rst = 1'b0;
        step();

        for (int r = 0; r < 13; r++) begin
            issue(tbl[r].m, tbl[r].a, tbl[r].d, tbl[r].mk, tbl[r].vbi, tbl[r].dst, tbl[r].wt);
            check("tbl_cmd_ready", Cmd_Ready, 1);
            if (tbl[r].chk_rd) begin
                check("tbl_rd_valid", Rd_Valid, 1);
                check("tbl_rd_vb", Rd_Vb, tbl[r].e_vb);
                if (tbl[r].chk_key) begin
                    check("tbl_rd_key", Rd_Key, tbl[r].e_key);
                    check("tbl_rd_mskb", Rd_Mskb, tbl[r].e_mk);
                end
            end
            if (tbl[r].chk_cnt) begin
                check("tbl_hit_count", Hit_Count, tbl[r].e_cnt);
                check("tbl_c_no_emit", Out_Valid, 0);
            end
            step();
            check("tbl_rd_pulse", Rd_Valid, 0);
        end

        // Two-beat burst at full throughput
        fire(8'h53, 0, 1'b0);
        // Same burst with a 3-cycle stall and writes attempted while busy
        fire(8'h53, 2, 1'b1);
        for (int a = 0; a < WORDS; a++) rd_check(4'(a));
        // No match
        fire(8'hAA, 0, 1'b0);
        check("miss_hit_count", Hit_Count, 0);

        // Soft clear then compare
        issue(MODE_CLR, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0);
        issue(MODE_C, 4'h0, 8'h53, 8'h00, 1'b0, 4'h0, 4'h0);
        check("clr_hit_count", Hit_Count, 0);

        // Reset in the middle of a burst
        issue(MODE_W, 4'd2, 8'h50, 8'hF0, 1'b1, 4'h9, 4'h2);
        issue(MODE_W, 4'd7, 8'h53, 8'hFF, 1'b1, 4'h4, 4'h1);
        Out_Ready = 1'b0;
        issue(MODE_F, 4'h0, 8'h53, 8'h00, 1'b0, 4'h0, 4'h0);
        step();
        check("pre_rst_ov", Out_Valid, 1);
        check("pre_rst_dst", DstID_Out, 4'h9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < WORDS; i++) model[i].vb = 1'b0;
        check("mid_rst_ov", Out_Valid, 0);
        check("mid_rst_ready", Cmd_Ready, 1);
        check("mid_rst_hits", Hit_Count, 0);
        rd_check(4'd2);
        rd_check(4'd7);

        // Randomised traffic against the reference model
        for (int it = 0; it < 300; it++) begin
            int op;
            int j;
            logic [7:0] k;
            op = $urandom_range(0, 99);
            j = $urandom_range(0, WORDS - 1);
            if ($urandom_range(0, 1) == 1) k = model[j].key ^ (8'($urandom) & ~model[j].mask);
            else k = 8'($urandom);
            if (op < 40) begin
                issue(MODE_W, 4'(j), 8'($urandom), 8'($urandom) & 8'($urandom | 32'h0F),
                      1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom));
            end else if (op < 65) begin
                fire(k, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
            end else if (op < 80) begin
                issue(MODE_C, 4'h0, k, 8'h00, 1'b0, 4'h0, 4'h0);
                check("rnd_hit_count", Hit_Count, model_count(k));
                check("rnd_c_no_emit", Out_Valid, 0);
            end else if (op < 95) begin
                rd_check(4'(j));
            end else begin
                issue(MODE_CLR, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tcam_fanout_engine.md
Name: tcam_fanout_engine

Overview:
- Parametrised successor to the single-bank TCAM neuron memory: stores WORDS ternary entries, each with a destination ID and a synaptic weight.
- On a fire command it searches all entries with an incoming packet key, latches the hit vector, then emits every hit's {DstID, Weight} one per accepted beat over a valid/ready stream, lowest address first.
- It sits between the spike router input and the synapse accumulator.
- It also provides write, read, compare-count and soft-clear modes.

Parameters:
ID_WIDTH, 4, packet / destination ID width
AXON_WIDTH, 2, axon field width in key
SYN_WIDTH, 2, synapse field width in key
WEIGHT_WIDTH, 4, stored weight width
WORDS, 16, number of TCAM entries (>=2)
ADDR_WIDTH, $clog2(WORDS), entry address width
BITS, ID_WIDTH+AXON_WIDTH+SYN_WIDTH, key width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Mode_In  in  3  command: I=000 W=001 R=010 F=011 C=100 CLR=101
Cmd_Valid  in  1  command strobe
Cmd_Ready  out  1  high when engine is IDLE
Data_In  in  BITS  key for W, search key for F/C
Mskb_In  in  BITS  care mask for W (1=care)
A_In  in  ADDR_WIDTH  entry address for W/R
Vbi_In  in  1  valid bit written by W
Dst_In  in  ID_WIDTH  destination ID written by W
Weight_In  in  WEIGHT_WIDTH  weight written by W
Rd_Valid  out  1  one-cycle pulse, read data valid
Rd_Key  out  BITS  stored key
Rd_Mskb  out  BITS  stored mask
Rd_Vb  out  1  stored valid bit
Out_Valid  out  1  fan-out beat valid
Out_Ready  in  1  downstream accept
DstID_Out  out  ID_WIDTH  hit entry destination ID
Weight_Out  out  WEIGHT_WIDTH  hit entry weight
Out_Last  out  1  marks final beat of a fire
Hit_Count  out  ADDR_WIDTH+1  hits of last F/C search
Miss  out  1  one-cycle pulse: F search with zero hits

Behaviour:
- Reset (rst=1 at a clk edge):
  - All valid bits cleared; key, mask and payload arrays not cleared.
  - State IDLE.
  - All outputs 0 except Cmd_Ready=1.
  - Reset mid-emission abandons the burst: Out_Valid=0 next cycle.
- Command acceptance: a command is taken when Cmd_Valid && Cmd_Ready. Cmd_Valid while busy is ignored; no queuing.
- Match rule: entry i hits iff vb[i] && ((key[i] ^ Data_In) & mask[i]) == 0. A mask of all zeros matches any key.
- W: entry A_In is updated at the same edge. Next cycle: Cmd_Ready=1; the new entry is visible to a search issued that cycle.
- R: registered read. Rd_Valid=1 with data in the cycle after acceptance. A read of an address written the previous cycle returns the new data.
- C: latches the hit vector. Hit_Count = popcount, valid the cycle after acceptance. No emission.
- CLR: all vb <= 0 in one cycle.
- F state machine:
  - IDLE -> SEARCH on an accepted F: hit vector and Hit_Count registered.
  - SEARCH, zero hits: Miss pulses 1 cycle; return to IDLE.
  - SEARCH, otherwise: go to EMIT.
  - EMIT: Out_Valid=1; outputs show the lowest set bit of the latched vector. Out_Last=1 when exactly one bit remains.
  - On Out_Valid && Out_Ready: clear that bit. If it was the last, go to IDLE with Out_Valid=0 next cycle; otherwise present the next hit in the next cycle.
  - Out_Ready=0 holds all outputs stable.
  - Latency: first beat 2 cycles after F acceptance. Throughput: 1 beat/cycle with Out_Ready tied high.
- Payload source: payload is read from the array live. Cmd_Ready=0 during SEARCH/EMIT, so the array cannot change within a burst.
- Cmd_Ready=0 in SEARCH and EMIT; it rises in the cycle the FSM is back in IDLE.

Decomposition:
- Package tcam_fanout_pkg:
  - mode_e enum (I, W, R, F, C, CLR) with the 3-bit codes above.
  - state_e (IDLE, SEARCH, EMIT).
  - Entry struct {key, mask, vb, dst, weight}.
- Sub-module tcam_prio_enc: parametrised WORDS-wide lowest-set-bit encoder with a one-hot-remaining "last" flag. Also used for popcount-free Out_Last detection.

Test Plan:
- Reset for 3 cycles, then R at address 5 -> Rd_Valid=1, Rd_Vb=0, Cmd_Ready=1.
- W addr 1 key 8'h00 mask 8'hFF dst 4'h3 wt 4'h7 vbi 1; then R addr 1 -> Rd_Key=8'h00, Rd_Mskb=8'hFF, Rd_Vb=1.
- Write addr 2 (key 8'h50, mask 8'hF0, dst 9, wt 2) and addr 7 (key 8'h53, mask 8'hFF, dst 4, wt 1); F key 8'h53 with Out_Ready=1 -> two beats (9,2,Last=0), (4,1,Last=1); Hit_Count=2.
- Same as above with Out_Ready low for 3 cycles on beat 1 -> outputs held at (9,2); Cmd_Valid=W during EMIT is ignored (addr unchanged on readback).
- F key 8'hAA with no match -> Miss=1 for 1 cycle, Out_Valid never rises, Cmd_Ready back the cycle after SEARCH.
- CLR then C key 8'h53 -> Hit_Count=0. Also assert rst during EMIT -> Out_Valid=0 and all vb=0 next cycle.
